// File: rtl/traffic_pkg.sv
// Shared light codes, fault codes and monitor state encoding for the
// traffic-light signal path.
package traffic_pkg;

  localparam logic [1:0] SIG_ERR = 2'b00;
  localparam logic [1:0] SIG_RED = 2'b01;
  localparam logic [1:0] SIG_GRN = 2'b10;
  localparam logic [1:0] SIG_YEL = 2'b11;

  localparam logic [1:0] FLT_ERR   = 2'b00;
  localparam logic [1:0] FLT_ORDER = 2'b01;
  localparam logic [1:0] FLT_SHORT = 2'b10;
  localparam logic [1:0] FLT_LONG  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RED   = 3'd1,
    ST_Y1    = 3'd2,
    ST_GREEN = 3'd3,
    ST_Y2    = 3'd4,
    ST_FAULT = 3'd5
  } mon_state_t;

  // Light code expected while sitting in a phase state.
  function automatic logic [1:0] phase_code(input mon_state_t s);
    case (s)
      ST_RED:   phase_code = SIG_RED;
      ST_Y1:    phase_code = SIG_YEL;
      ST_GREEN: phase_code = SIG_GRN;
      ST_Y2:    phase_code = SIG_YEL;
      default:  phase_code = SIG_ERR;
    endcase
  endfunction

  // Phase that legally follows the given one.
  function automatic mon_state_t phase_next(input mon_state_t s);
    case (s)
      ST_RED:   phase_next = ST_Y1;
      ST_Y1:    phase_next = ST_GREEN;
      ST_GREEN: phase_next = ST_Y2;
      ST_Y2:    phase_next = ST_RED;
      default:  phase_next = ST_INIT;
    endcase
  endfunction

endpackage

// File: rtl/traffic_monitor_flash_gen.sv
// Fault-mode flasher: blink holds 1 while disabled, then toggles every
// FLASH_HALF enabled cycles so the flashing always starts "on".
module flash_gen
  import traffic_pkg::*;
#(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic blink
);

  localparam int unsigned CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt;

  // Half-period counter wrapping modulo FLASH_HALF; toggles blink on wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (!enable) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_monitor.sv
// Checks the upstream traffic-light code stream against the expected
// red / short yellow / green / long yellow cycle, drives the lamps and a
// remaining-cycles countdown, and latches a fault with flashing yellow on
// any violation until software clears it.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned RED_LEN    = 10,
  parameter int unsigned Y1_LEN     = 1,
  parameter int unsigned GRN_LEN    = 9,
  parameter int unsigned Y2_LEN     = 2,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] signal_in,
  input  logic       clr_fault,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic [4:0] remain,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [4:0] RED_L = 5'(RED_LEN);
  localparam logic [4:0] Y1_L  = 5'(Y1_LEN);
  localparam logic [4:0] GRN_L = 5'(GRN_LEN);
  localparam logic [4:0] Y2_L  = 5'(Y2_LEN);

  function automatic logic [4:0] phase_len(input mon_state_t s);
    case (s)
      ST_RED:   phase_len = RED_L;
      ST_Y1:    phase_len = Y1_L;
      ST_GREEN: phase_len = GRN_L;
      ST_Y2:    phase_len = Y2_L;
      default:  phase_len = '0;
    endcase
  endfunction

  mon_state_t state, state_nx;
  logic [4:0] ph_cnt, ph_cnt_nx;
  logic       fault_nx;
  logic [1:0] code_nx;
  logic       red_q, grn_q, yel_q;
  logic       blink;

  logic [1:0] cur_code;
  logic [4:0] cur_len;
  mon_state_t succ;

  // Next-state decision: phase rules are checked in priority order.
  always_comb begin
    state_nx  = state;
    ph_cnt_nx = ph_cnt;
    fault_nx  = fault;
    code_nx   = fault_code;
    cur_code  = phase_code(state);
    cur_len   = phase_len(state);
    succ      = phase_next(state);
    case (state)
      ST_INIT: begin
        ph_cnt_nx = '0;
        if (signal_in == SIG_RED) begin
          state_nx  = ST_RED;
          ph_cnt_nx = 5'd1;
        end else if (signal_in != SIG_ERR) begin
          state_nx = ST_FAULT;
          fault_nx = 1'b1;
          code_nx  = FLT_ORDER;
        end
      end
      ST_RED, ST_Y1, ST_GREEN, ST_Y2: begin
        if (signal_in == SIG_ERR) begin
          state_nx  = ST_FAULT;
          ph_cnt_nx = '0;
          fault_nx  = 1'b1;
          code_nx   = FLT_ERR;
        end else if (signal_in == cur_code && ph_cnt < cur_len) begin
          ph_cnt_nx = ph_cnt + 5'd1;
        end else if (signal_in == cur_code) begin
          state_nx  = ST_FAULT;
          ph_cnt_nx = '0;
          fault_nx  = 1'b1;
          code_nx   = FLT_LONG;
        end else if (signal_in == phase_code(succ) && ph_cnt == cur_len) begin
          state_nx  = succ;
          ph_cnt_nx = 5'd1;
        end else if (signal_in == phase_code(succ)) begin
          state_nx  = ST_FAULT;
          ph_cnt_nx = '0;
          fault_nx  = 1'b1;
          code_nx   = FLT_SHORT;
        end else begin
          state_nx  = ST_FAULT;
          ph_cnt_nx = '0;
          fault_nx  = 1'b1;
          code_nx   = FLT_ORDER;
        end
      end
      ST_FAULT: begin
        ph_cnt_nx = '0;
        if (clr_fault) begin
          state_nx = ST_INIT;
          fault_nx = 1'b0;
          code_nx  = FLT_ERR;
        end
      end
      default: begin
        state_nx  = ST_INIT;
        ph_cnt_nx = '0;
      end
    endcase
  end

  // State, counters and lamp/countdown registers, all from the next-state view.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_INIT;
      ph_cnt     <= '0;
      fault      <= 1'b0;
      fault_code <= FLT_ERR;
      red_q      <= 1'b0;
      grn_q      <= 1'b0;
      yel_q      <= 1'b0;
      remain     <= '0;
    end else begin
      state      <= state_nx;
      ph_cnt     <= ph_cnt_nx;
      fault      <= fault_nx;
      fault_code <= code_nx;
      red_q      <= (state_nx == ST_RED);
      grn_q      <= (state_nx == ST_GREEN);
      yel_q      <= (state_nx == ST_Y1) || (state_nx == ST_Y2);
      remain     <= phase_len(state_nx) - ph_cnt_nx;
    end
  end

  // Flasher is held "on" outside FAULT so the first fault cycle shows yellow.
  flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk    (clk),
    .rstn   (rstn),
    .enable (state == ST_FAULT),
    .blink  (blink)
  );

  // Lamp drive; in FAULT only the flashing yellow is lit.
  always_comb begin
    lamp_red    = red_q && !fault;
    lamp_green  = grn_q && !fault;
    lamp_yellow = fault ? blink : yel_q;
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: directed scenarios plus a
// randomly perturbed upstream stream, checked against a phase-table model.
module tb_traffic_monitor;

  localparam int FH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] signal_in;
  logic       clr_fault;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [4:0] remain;
  logic [1:0] fault_code;

  int n_cmp = 0;
  int n_err = 0;
  string tag = "none";

  // Reference model: mode 0 init, 1 in phase m_ph (0..3), 2 fault.
  int p_code[4] = '{1, 3, 2, 3};
  int p_len[4]  = '{10, 1, 9, 2};
  int m_mode, m_ph, m_cnt, m_code, m_fc;

  traffic_monitor #(
    .RED_LEN(10), .Y1_LEN(1), .GRN_LEN(9), .Y2_LEN(2), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rstn(rstn), .signal_in(signal_in), .clr_fault(clr_fault),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .remain(remain), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] upstream(input int k);
    int p;
    if (k == 0) return 2'b00;
    p = (k - 1) % 22;
    if (p < 10) return 2'b01;
    if (p < 11) return 2'b11;
    if (p < 20) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_cnt = 0; m_code = 0; m_fc = 0;
  endtask

  task automatic model_fault(input int c);
    m_mode = 2; m_code = c; m_fc = 0;
  endtask

  task automatic model_step(input int s, input int c);
    int nx;
    if (m_mode == 0) begin
      if (s == 1) begin m_mode = 1; m_ph = 0; m_cnt = 1; end
      else if (s != 0) model_fault(1);
    end else if (m_mode == 1) begin
      nx = (m_ph + 1) % 4;
      if (s == 0) model_fault(0);
      else if (s == p_code[m_ph]) begin
        if (m_cnt < p_len[m_ph]) m_cnt++;
        else model_fault(3);
      end else if (s == p_code[nx]) begin
        if (m_cnt == p_len[m_ph]) begin m_ph = nx; m_cnt = 1; end
        else model_fault(2);
      end else model_fault(1);
    end else begin
      if (c != 0) begin m_mode = 0; m_code = 0; m_fc = 0; end
      else m_fc++;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s/%s: got %0d expected %0d", tag, name, got, want);
    end
  endtask

  task automatic check_model();
    logic er, ey, eg;
    int rem;
    er = (m_mode == 1) && (m_ph == 0);
    eg = (m_mode == 1) && (m_ph == 2);
    ey = ((m_mode == 1) && (m_ph == 1 || m_ph == 3)) ||
         ((m_mode == 2) && (((m_fc / FH) % 2) == 0));
    rem = (m_mode == 1) ? p_len[m_ph] - m_cnt : 0;
    chk("red",    {7'd0, lamp_red},    {7'd0, er});
    chk("yellow", {7'd0, lamp_yellow}, {7'd0, ey});
    chk("green",  {7'd0, lamp_green},  {7'd0, eg});
    chk("remain", {3'd0, remain},      8'(rem));
    chk("fault",  {7'd0, fault},       {7'd0, (m_mode == 2)});
    chk("code",   {6'd0, fault_code},  8'(m_code));
  endtask

  task automatic cyc(input logic [1:0] s, input logic c);
    signal_in = s;
    clr_fault = c;
    @(posedge clk);
    model_step(int'(s), int'(c));
    #1;
    check_model();
  endtask

  initial begin
    int k;
    rstn = 1'b0; signal_in = 2'b00; clr_fault = 1'b0;
    model_reset();
    tag = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rstn = 1'b1;

    // Legal upstream sequence, three frames.
    tag = "legal";
    for (int i = 0; i <= 66; i++) begin
      cyc(upstream(i), 1'b0);
      if (i == 1)  chk("first_red_remain", {3'd0, remain}, 8'd9);
      if (i == 10) chk("red_end_remain", {3'd0, remain}, 8'd0);
      if (i == 23) chk("wrap_red", {7'd0, lamp_red}, 8'd1);
    end

    // Error code on the 4th green cycle, then watch the flashing.
    tag = "err";
    for (int i = 1; i <= 14; i++) cyc(upstream(i), 1'b0);
    cyc(2'b00, 1'b0);
    chk("err_fault", {7'd0, fault}, 8'd1);
    chk("err_code", {6'd0, fault_code}, 8'd0);
    chk("err_yel0", {7'd0, lamp_yellow}, 8'd1);
    for (int i = 0; i < 9; i++) cyc(2'($urandom_range(0, 3)), 1'b0);
    cyc(2'b00, 1'b1);

    // Short red.
    tag = "short";
    for (int i = 0; i < 8; i++) cyc(2'b01, 1'b0);
    cyc(2'b11, 1'b0);
    chk("short_code", {6'd0, fault_code}, 8'd2);
    cyc(2'b00, 1'b1);

    // Long green.
    tag = "long";
    for (int i = 1; i <= 11; i++) cyc(upstream(i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(2'b10, 1'b0);
    chk("long_code", {6'd0, fault_code}, 8'd3);
    cyc(2'b00, 1'b1);

    // Order fault, then clear with red present.
    tag = "order";
    for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0);
    cyc(2'b10, 1'b0);
    chk("order_code", {6'd0, fault_code}, 8'd1);
    cyc(2'b01, 1'b1);
    chk("clr_fault0", {7'd0, fault}, 8'd0);
    cyc(2'b01, 1'b0);
    chk("clr_red_remain", {3'd0, remain}, 8'd9);

    // Async reset in the middle of Y2, between edges.
    tag = "async";
    for (int i = 2; i <= 21; i++) cyc(upstream(i), 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_model();
    #2;
    rstn = 1'b1;
    cyc(2'b00, 1'b0);

    // Randomly perturbed upstream stream with occasional clears.
    tag = "random";
    k = 1;
    for (int i = 0; i < 600; i++) begin
      logic [1:0] s;
      logic c;
      s = upstream(k);
      if ($urandom_range(0, 39) == 0) s = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 11) == 0);
      cyc(s, c);
      k++;
      if (m_mode == 0) k = ($urandom_range(0, 1) == 0) ? 0 : 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
